fir_mac_sequencer: RTL and testbench

Control FSM for the FIR datapath. On each accepted input sample it enables the shift register, then walks tap_index through 0..NUM_TAPS-1 to drive the tap MUX and coefficient select, and gates the MAC unit. It waits out the MAC pipeline latency, then pulses result valid. It sits between the sample source and the shift_register / tap MUX / MAC / output register.

---
 rtl/fir_mac_sequencer_pkg.sv | 36 +++
 rtl/fir_tap_counter.sv | 23 ++
 rtl/fir_mac_sequencer.sv | 140 ++++++++++++++
 tb/tb_fir_mac_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fir_mac_sequencer_pkg.sv
// Shared types for the FIR MAC sequencer: state encoding, control bundle and its decode.
package fir_mac_sequencer_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LAT_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic busy;
        logic shift_en;
        logic mac_en;
        logic mac_clear;
        logic out_valid;
        logic overrun;
    } seq_ctrl_t;

    // Control values for the cycle the FSM is about to enter; registered by the caller.
    function automatic seq_ctrl_t decode_ctrl(input state_e nxt, input state_e cur, input logic drop);
        seq_ctrl_t c;
        c.busy      = (nxt != ST_IDLE);
        c.shift_en  = (nxt == ST_SHIFT);
        c.mac_en    = (nxt == ST_MAC);
        c.mac_clear = (nxt == ST_MAC) && (cur != ST_MAC);
        c.out_valid = (nxt == ST_DONE);
        c.overrun   = drop;
        return c;
    endfunction

endpackage

// File: rtl/fir_tap_counter.sv
// Up-counter that wraps to zero after reaching last; clear forces zero.
module fir_tap_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= (count == last) ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Control FSM for the FIR datapath: shift, walk taps through the MAC, drain, flag result.
module fir_mac_sequencer
    import fir_mac_sequencer_pkg::*;
#(
    parameter int unsigned NUM_TAPS    = 8,
    parameter int unsigned MAC_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        sample_valid,
    output logic                        busy,
    output logic                        shift_en,
    output logic [$clog2(NUM_TAPS)-1:0] tap_index,
    output logic                        mac_en,
    output logic                        mac_clear,
    output logic                        out_valid,
    output logic                        overrun
);

    localparam int unsigned TAP_W      = $clog2(NUM_TAPS);
    localparam int unsigned DRAIN_LAST = (MAC_LATENCY > 0) ? MAC_LATENCY - 1 : 0;

    state_e     state;
    state_e     state_next;
    seq_ctrl_t  ctrl;
    logic       accept;
    logic       drop;
    logic       tap_clear;
    logic       tap_inc;
    logic       tap_last;
    logic       drain_clear;
    logic       drain_inc;
    logic       drain_last;
    logic [LAT_W-1:0] drain_count;

    assign tap_last   = (tap_index == TAP_W'(NUM_TAPS - 1));
    assign drain_last = (drain_count == LAT_W'(DRAIN_LAST));

    fir_tap_counter #(
        .WIDTH (TAP_W)
    ) u_tap_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (tap_clear),
        .inc   (tap_inc),
        .last  (TAP_W'(NUM_TAPS - 1)),
        .count (tap_index)
    );

    fir_tap_counter #(
        .WIDTH (LAT_W)
    ) u_drain_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (drain_clear),
        .inc   (drain_inc),
        .last  (LAT_W'(DRAIN_LAST)),
        .count (drain_count)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and counter controls.
    always_comb begin
        state_next  = state;
        tap_clear   = 1'b0;
        tap_inc     = 1'b0;
        drain_clear = 1'b0;
        drain_inc   = 1'b0;
        accept      = enable && sample_valid;
        drop        = 1'b0;

        unique case (state)
            ST_IDLE: begin
                tap_clear   = 1'b1;
                drain_clear = 1'b1;
                if (accept) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                tap_clear   = 1'b1;
                drain_clear = 1'b1;
                drop        = accept;
                state_next  = ST_MAC;
            end
            ST_MAC: begin
                tap_inc     = 1'b1;
                drain_clear = 1'b1;
                drop        = accept;
                if (tap_last) begin
                    state_next = (MAC_LATENCY > 0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                tap_clear = 1'b1;
                drain_inc = 1'b1;
                drop      = accept;
                if (drain_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                tap_clear   = 1'b1;
                drain_clear = 1'b1;
                state_next  = accept ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                tap_clear   = 1'b1;
                drain_clear = 1'b1;
                state_next  = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl <= '0;
        end else begin
            ctrl <= decode_ctrl(state_next, state, drop);
        end
    end

    assign busy      = ctrl.busy;
    assign shift_en  = ctrl.shift_en;
    assign mac_en    = ctrl.mac_en;
    assign mac_clear = ctrl.mac_clear;
    assign out_valid = ctrl.out_valid;
    assign overrun   = ctrl.overrun;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer: default instance plus a NUM_TAPS=5 / MAC_LATENCY=0 instance.
module tb_fir_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_a = 1'b1;
    logic       sv_a = 1'b0;
    logic       en_b = 1'b1;
    logic       sv_b = 1'b0;

    logic       busy_a, shift_a, mac_a, clr_a, ov_a, ovr_a;
    logic [2:0] tap_a;
    logic       busy_b, shift_b, mac_b, clr_b, ov_b, ovr_b;
    logic [2:0] tap_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int ov_a_seen = 0, ov_b_seen = 0, ovr_a_seen = 0, ovr_b_seen = 0;

    int ov_a_q[$];
    int ov_b_q[$];
    int ovr_a_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_mac_sequencer #(.NUM_TAPS(8), .MAC_LATENCY(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .sample_valid(sv_a),
        .busy(busy_a), .shift_en(shift_a), .tap_index(tap_a), .mac_en(mac_a),
        .mac_clear(clr_a), .out_valid(ov_a), .overrun(ovr_a)
    );

    fir_mac_sequencer #(.NUM_TAPS(5), .MAC_LATENCY(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .sample_valid(sv_b),
        .busy(busy_b), .shift_en(shift_b), .tap_index(tap_b), .mac_en(mac_b),
        .mac_clear(clr_b), .out_valid(ov_b), .overrun(ovr_b)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_sv(input bit b, input logic v);
        if (b) sv_b = v;
        else   sv_a = v;
    endtask

    // Pulse one sample at cycle k and check every control output over the whole frame.
    task automatic run_frame(input bit b, input int k, input int inj);
        int nt, ml, d;
        logic o_sh, o_mac, o_clr, o_busy;
        logic [2:0] o_tap;
        nt = b ? 5 : 8;
        ml = b ? 0 : 1;
        goto(k);
        set_sv(b, 1'b1);
        if (b) ov_b_q.push_back(k + 2 + nt + ml);
        else   ov_a_q.push_back(k + 2 + nt + ml);
        for (int c = k + 1; c <= k + nt + ml + 3; c++) begin
            goto(c);
            d = c - k;
            set_sv(b, c == inj);
            if (c == inj) ovr_a_q.push_back(c + 1);
            o_sh   = b ? shift_b : shift_a;
            o_mac  = b ? mac_b   : mac_a;
            o_clr  = b ? clr_b   : clr_a;
            o_busy = b ? busy_b  : busy_a;
            o_tap  = b ? tap_b   : tap_a;
            check_eq("shift_en",  int'(o_sh),   int'(d == 1));
            check_eq("mac_en",    int'(o_mac),  int'(d >= 2 && d <= nt + 1));
            check_eq("mac_clear", int'(o_clr),  int'(d == 2));
            check_eq("busy",      int'(o_busy), int'(d >= 1 && d <= nt + ml + 2));
            check_eq("tap_index", int'(o_tap),  (d >= 2 && d <= nt + 1) ? d - 2 : 0);
        end
    endtask

    // Result and overrun pulses are matched against the cycles predicted when stimulus was driven.
    always @(negedge clk) begin
        if (ov_a) begin
            ov_a_seen++;
            if (ov_a_q.size() == 0) check_eq("out_valid_a_spurious", cyc, -1);
            else                    check_eq("out_valid_a_cycle", cyc, ov_a_q.pop_front());
        end
        if (ov_b) begin
            ov_b_seen++;
            if (ov_b_q.size() == 0) check_eq("out_valid_b_spurious", cyc, -1);
            else                    check_eq("out_valid_b_cycle", cyc, ov_b_q.pop_front());
        end
        if (ovr_a) begin
            ovr_a_seen++;
            if (ovr_a_q.size() == 0) check_eq("overrun_a_spurious", cyc, -1);
            else                     check_eq("overrun_a_cycle", cyc, ovr_a_q.pop_front());
        end
        if (ovr_b) begin
            ovr_b_seen++;
            check_eq("overrun_b_spurious", cyc, -1);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        goto(2);
        check_eq("reset_a", int'({busy_a, shift_a, mac_a, clr_a, ov_a, ovr_a, tap_a}), 0);
        check_eq("reset_b", int'({busy_b, shift_b, mac_b, clr_b, ov_b, ovr_b, tap_b}), 0);
        goto(3);
        rst_n = 1'b1;

        run_frame(1'b0, 10, -1);

        // Back-to-back: new sample offered in the DONE cycle.
        goto(30); sv_a = 1'b1; ov_a_q.push_back(41);
        goto(31); sv_a = 1'b0;
        goto(41); sv_a = 1'b1; ov_a_q.push_back(52);
        check_eq("b2b_busy_done", int'(busy_a), 1);
        goto(42); sv_a = 1'b0;
        check_eq("b2b_shift_en", int'(shift_a), 1);
        check_eq("b2b_busy", int'(busy_a), 1);
        goto(43);
        check_eq("b2b_mac_clear", int'(clr_a), 1);
        goto(53);
        check_eq("b2b_idle", int'(busy_a), 0);

        // Overrun injected while tap_index==3.
        run_frame(1'b0, 60, 65);

        // Enable low: samples ignored, no overrun.
        for (int c = 80; c <= 85; c++) begin
            goto(c);
            if (c > 80) begin
                check_eq("en0_shift_en", int'(shift_a), 0);
                check_eq("en0_busy", int'(busy_a), 0);
            end
            sv_a = (c < 85);
            en_a = (c >= 85);
        end

        // Enable dropped mid-computation: result still arrives on schedule.
        goto(90); sv_a = 1'b1; en_a = 1'b1; ov_a_q.push_back(101);
        goto(91); sv_a = 1'b0;
        goto(93); en_a = 1'b0;
        goto(95); sv_a = 1'b1;
        check_eq("en_drop_mac_en", int'(mac_a), 1);
        goto(96); sv_a = 1'b0;
        goto(102);
        check_eq("en_drop_idle", int'(busy_a), 0);
        goto(103); en_a = 1'b1;

        // Async reset at tap_index==5 aborts the frame.
        goto(110); sv_a = 1'b1;
        goto(111); sv_a = 1'b0;
        goto(117);
        check_eq("pre_reset_tap", int'(tap_a), 5);
        #2 rst_n = 1'b0;
        #1 check_eq("async_reset_outs", int'({busy_a, shift_a, mac_a, clr_a, ov_a, ovr_a, tap_a}), 0);
        goto(120); rst_n = 1'b1;
        run_frame(1'b0, 130, -1);

        // Second parameter set: NUM_TAPS=5, MAC_LATENCY=0.
        run_frame(1'b1, 150, -1);
        goto(170); sv_b = 1'b1; ov_b_q.push_back(177);
        goto(171); sv_b = 1'b0;
        goto(177); sv_b = 1'b1; ov_b_q.push_back(184);
        goto(178); sv_b = 1'b0;
        check_eq("b_b2b_shift_en", int'(shift_b), 1);

        goto(190);
        check_eq("out_valid_a_count", ov_a_seen, 6);
        check_eq("out_valid_b_count", ov_b_seen, 3);
        check_eq("overrun_a_count", ovr_a_seen, 1);
        check_eq("overrun_b_count", ovr_b_seen, 0);
        check_eq("ov_a_queue_left", ov_a_q.size(), 0);
        check_eq("ov_b_queue_left", ov_b_q.size(), 0);
        check_eq("ovr_a_queue_left", ovr_a_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
